// File: rtl/memory_bus_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : memory_bus_arbiter
// Purpose  : Two-master arbiter sharing one memory_controller bus port between
//            an instruction-fetch requester (port 0) and a data load/store
//            requester (port 1). Each transfer is sequenced through the
//            rd_en/wr_en/byte_en/busy handshake, alternating on contention.
// Ports    : clock, reset (async, active-low)
//            mN_rd_en, mN_wr_en, mN_byte_en, mN_addr, mN_wr_data  - master N request
//            mN_rd_data (registered), mN_busy (combinational)     - master N response
//            mem_rd_en, mem_wr_en, mem_byte_en, mem_addr, wr_data - to memory_controller
//            rd_data, mem_busy                                    - from memory_controller
// Revision : 1.0 - initial release
// ============================================================================
module memory_bus_arbiter #(
    parameter int ADDR_SIZE = 64,
    parameter int DATA_SIZE = 64,
    parameter int BYTE_NUM  = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 m0_rd_en,
    input  logic                 m0_wr_en,
    input  logic [BYTE_NUM-1:0]  m0_byte_en,
    input  logic [ADDR_SIZE-1:0] m0_addr,
    input  logic [DATA_SIZE-1:0] m0_wr_data,
    output logic [DATA_SIZE-1:0] m0_rd_data,
    output logic                 m0_busy,
    input  logic                 m1_rd_en,
    input  logic                 m1_wr_en,
    input  logic [BYTE_NUM-1:0]  m1_byte_en,
    input  logic [ADDR_SIZE-1:0] m1_addr,
    input  logic [DATA_SIZE-1:0] m1_wr_data,
    output logic [DATA_SIZE-1:0] m1_rd_data,
    output logic                 m1_busy,
    output logic                 mem_rd_en,
    output logic                 mem_wr_en,
    output logic [BYTE_NUM-1:0]  mem_byte_en,
    output logic [ADDR_SIZE-1:0] mem_addr,
    output logic [DATA_SIZE-1:0] wr_data,
    input  logic [DATA_SIZE-1:0] rd_data,
    input  logic                 mem_busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;

    logic                   r_grant;
    logic                   r_last;
    logic                   r_mem_rd_en;
    logic                   r_mem_wr_en;
    logic [BYTE_NUM-1:0]    r_mem_byte_en;
    logic [ADDR_SIZE-1:0]   r_mem_addr;
    logic [DATA_SIZE-1:0]   r_wr_data;
    logic [DATA_SIZE-1:0]   r_m0_rd_data;
    logic [DATA_SIZE-1:0]   r_m1_rd_data;

    logic                   w_req0;
    logic                   w_req1;
    logic                   w_sel;
    logic                   w_sel_rd;
    logic                   w_sel_wr;
    logic [BYTE_NUM-1:0]    w_sel_byte_en;
    logic [ADDR_SIZE-1:0]   w_sel_addr;
    logic [DATA_SIZE-1:0]   w_sel_wr_data;

    assign w_req0 = m0_rd_en | m0_wr_en;
    assign w_req1 = m1_rd_en | m1_wr_en;

    // On a tie the port that did not win last time is chosen; otherwise the
    // single requester (w_req1 selects port 1, else port 0).
    assign w_sel         = (w_req0 & w_req1) ? ~r_last : w_req1;
    assign w_sel_rd      = w_sel ? m1_rd_en   : m0_rd_en;
    assign w_sel_wr      = w_sel ? m1_wr_en   : m0_wr_en;
    assign w_sel_byte_en = w_sel ? m1_byte_en : m0_byte_en;
    assign w_sel_addr    = w_sel ? m1_addr    : m0_addr;
    assign w_sel_wr_data = w_sel ? m1_wr_data : m0_wr_data;

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_req0 | w_req1) w_next_state = S_REQ;
            S_REQ:   if (mem_busy)        w_next_state = S_WAIT;
            S_WAIT:  if (!mem_busy)       w_next_state = S_DONE;
            S_DONE:                       w_next_state = S_IDLE;
            default:                      w_next_state = S_IDLE;
        endcase
    end

    // Grant, bus output registers and read-data capture
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_grant       <= 1'b0;
            r_last        <= 1'b1;
            r_mem_rd_en   <= 1'b0;
            r_mem_wr_en   <= 1'b0;
            r_mem_byte_en <= '0;
            r_mem_addr    <= '0;
            r_wr_data     <= '0;
            r_m0_rd_data  <= '0;
            r_m1_rd_data  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req0 | w_req1) begin
                        r_grant       <= w_sel;
                        r_last        <= w_sel;
                        // A write wins when a master raises both enables
                        r_mem_wr_en   <= w_sel_wr;
                        r_mem_rd_en   <= w_sel_rd & ~w_sel_wr;
                        r_mem_byte_en <= w_sel_byte_en;
                        r_mem_addr    <= w_sel_addr;
                        r_wr_data     <= w_sel_wr_data;
                    end
                end
                S_WAIT: begin
                    if (!mem_busy) begin
                        r_mem_rd_en <= 1'b0;
                        r_mem_wr_en <= 1'b0;
                        if (r_mem_rd_en) begin
                            if (r_grant) begin
                                r_m1_rd_data <= rd_data;
                            end else begin
                                r_m0_rd_data <= rd_data;
                            end
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign mem_rd_en   = r_mem_rd_en;
    assign mem_wr_en   = r_mem_wr_en;
    assign mem_byte_en = r_mem_byte_en;
    assign mem_addr    = r_mem_addr;
    assign wr_data     = r_wr_data;
    assign m0_rd_data  = r_m0_rd_data;
    assign m1_rd_data  = r_m1_rd_data;

    // Busy drops only in the DONE cycle of the master's own transfer; gated
    // by reset so a held request never reads as pending during reset.
    assign m0_busy = reset & w_req0 & ~((r_state == S_DONE) & ~r_grant);
    assign m1_busy = reset & w_req1 & ~((r_state == S_DONE) &  r_grant);

endmodule
`default_nettype wire

// File: tb/tb_memory_bus_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_memory_bus_arbiter
// Purpose  : Self-checking bench for memory_bus_arbiter. Masters push expected
//            bus/completion items into per-port queues; a monitor pops and
//            compares them as the DUT presents grants and completions.
//            Port 0 uses addresses 0x0000-0x00F8, port 1 uses 0x1000-0x10F8.
// Revision : 1.0 - initial release
// ============================================================================
module tb_memory_bus_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        m0_rd_en, m0_wr_en, m1_rd_en, m1_wr_en;
    logic [7:0]  m0_byte_en, m1_byte_en, mem_byte_en;
    logic [63:0] m0_addr, m1_addr, m0_wr_data, m1_wr_data;
    logic [63:0] m0_rd_data, m1_rd_data;
    logic        m0_busy, m1_busy;
    logic        mem_rd_en, mem_wr_en;
    logic [63:0] mem_addr, wr_data, rd_data;
    logic        mem_busy;

    always #5 clock = ~clock;

    memory_bus_arbiter dut (
        .clock(clock), .reset(reset),
        .m0_rd_en(m0_rd_en), .m0_wr_en(m0_wr_en), .m0_byte_en(m0_byte_en),
        .m0_addr(m0_addr), .m0_wr_data(m0_wr_data), .m0_rd_data(m0_rd_data), .m0_busy(m0_busy),
        .m1_rd_en(m1_rd_en), .m1_wr_en(m1_wr_en), .m1_byte_en(m1_byte_en),
        .m1_addr(m1_addr), .m1_wr_data(m1_wr_data), .m1_rd_data(m1_rd_data), .m1_busy(m1_busy),
        .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_byte_en(mem_byte_en),
        .mem_addr(mem_addr), .wr_data(wr_data), .rd_data(rd_data), .mem_busy(mem_busy)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] nw,
                                          input logic [7:0] be);
        logic [63:0] r;
        r = old;
        for (int i = 0; i < 8; i++) if (be[i]) r[8*i +: 8] = nw[8*i +: 8];
        return r;
    endfunction

    // ---------------- memory_controller model ----------------
    int          mem_lat = 2;   // 0 selects a random latency per access
    logic [63:0] dev_mem [0:63];
    logic [63:0] dev_valid;
    logic        mem_init = 1'b0;
    int          mcnt;
    logic [1:0]  mst;

    function automatic logic [5:0] didx(input logic [63:0] a);
        return {a[12], a[7:3]};
    endfunction

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem_busy <= 1'b0;
            mst      <= 2'd0;
            mcnt     <= 0;
            if (!mem_init) begin
                dev_valid  <= 64'h1;
                dev_mem[0] <= 64'h0000_0093;
                rd_data    <= '0;
                mem_init   <= 1'b1;
            end
        end else begin
            case (mst)
                2'd0: if (mem_rd_en | mem_wr_en) begin
                    mem_busy <= 1'b1;
                    mcnt     <= (mem_lat == 0) ? int'($urandom_range(1, 4)) : mem_lat;
                    mst      <= 2'd1;
                end
                2'd1: if (mcnt <= 1) begin
                    mem_busy <= 1'b0;
                    mst      <= 2'd2;
                    if (mem_wr_en) begin
                        dev_mem[didx(mem_addr)] <= merge(dev_valid[didx(mem_addr)] ?
                            dev_mem[didx(mem_addr)] : 64'h0, wr_data, mem_byte_en);
                        dev_valid[didx(mem_addr)] <= 1'b1;
                    end else begin
                        rd_data <= dev_valid[didx(mem_addr)] ? dev_mem[didx(mem_addr)] : 64'h0;
                    end
                end else begin
                    mcnt <= mcnt - 1;
                end
                default: if (!(mem_rd_en | mem_wr_en)) mst <= 2'd0;
            endcase
        end
    end

    // ---------------- reference model and scoreboard ----------------
    typedef struct {
        logic        wr;
        logic [7:0]  be;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] rdata;
    } txn_t;

    logic [63:0] ref_mem [logic [63:0]];
    txn_t q_bus0[$], q_bus1[$], q_done0[$], q_done1[$];
    bit   grant_log[$];
    int   last_gap;
    int   m1_busy_cnt;

    function automatic logic [63:0] ref_read(input logic [63:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 64'h0;
    endfunction

    task automatic issue(input int p, input logic rd, input logic wr, input logic [7:0] be,
                         input logic [63:0] addr, input logic [63:0] data);
        txn_t t;
        t.wr = wr; t.be = be; t.addr = addr; t.wdata = data; t.rdata = '0;
        if (wr) ref_mem[addr] = merge(ref_read(addr), data, be);
        else    t.rdata = ref_read(addr);
        if (p == 0) begin q_bus0.push_back(t); q_done0.push_back(t); end
        else        begin q_bus1.push_back(t); q_done1.push_back(t); end
        @(posedge clock); #1;
        if (p == 0) begin
            m0_rd_en = rd; m0_wr_en = wr; m0_byte_en = be; m0_addr = addr; m0_wr_data = data;
        end else begin
            m1_rd_en = rd; m1_wr_en = wr; m1_byte_en = be; m1_addr = addr; m1_wr_data = data;
        end
    endtask

    task automatic wait_done(input int p);
        int n = 0;
        forever begin
            @(negedge clock);
            if (((p == 0) ? m0_busy : m1_busy) == 1'b0) break;
            n++;
            if (n > 300) begin
                checks++; failures++;
                $display("FAIL wait_done_timeout port=%0d actual=busy expected=done", p);
                break;
            end
        end
    endtask

    task automatic release_port(input int p);
        @(posedge clock); #1;
        if (p == 0) begin m0_rd_en = 0; m0_wr_en = 0; end
        else        begin m1_rd_en = 0; m1_wr_en = 0; end
    endtask

    task automatic txn(input int p, input logic rd, input logic wr, input logic [7:0] be,
                       input logic [63:0] addr, input logic [63:0] data);
        issue(p, rd, wr, be, addr, data);
        wait_done(p);
        release_port(p);
    endtask

    // Monitor: grant order, bus contents and completions
    initial begin : monitor
        bit   rr_last, prev_en, prev_r0, prev_r1, en, g, exp_g, r0, r1;
        int   gap;
        txn_t t;
        rr_last = 1; prev_en = 0; prev_r0 = 0; prev_r1 = 0; gap = 100;
        forever begin
            @(negedge clock);
            if (!reset) begin
                rr_last = 1; prev_en = 0; prev_r0 = 0; prev_r1 = 0; gap = 100;
                continue;
            end
            if (m1_busy) m1_busy_cnt++;
            en = mem_rd_en | mem_wr_en;
            r0 = m0_rd_en | m0_wr_en;
            r1 = m1_rd_en | m1_wr_en;
            if (en && !prev_en) begin
                g = mem_addr[12];
                chk("grant_had_request", {63'h0, prev_r0 | prev_r1}, 64'h1);
                exp_g = (prev_r0 && prev_r1) ? ~rr_last : prev_r1;
                chk("grant_port", {63'h0, g}, {63'h0, exp_g});
                chk("idle_gap_min", {63'h0, gap >= 2}, 64'h1);
                last_gap = gap;
                rr_last  = g;
                grant_log.push_back(g);
                if ((g ? q_bus1.size() : q_bus0.size()) == 0) begin
                    chk("bus_unexpected_grant", 64'h1, 64'h0);
                end else begin
                    t = g ? q_bus1.pop_front() : q_bus0.pop_front();
                    chk("bus_wr_en", {63'h0, mem_wr_en}, {63'h0, t.wr});
                    chk("bus_rd_en", {63'h0, mem_rd_en}, {63'h0, ~t.wr});
                    chk("bus_addr", mem_addr, t.addr);
                    chk("bus_byte_en", {56'h0, mem_byte_en}, {56'h0, t.be});
                    if (t.wr) chk("bus_wr_data", wr_data, t.wdata);
                end
                gap = 0;
            end
            if (!en) gap++;
            if (r0 && !m0_busy) begin
                if (q_done0.size() == 0) chk("done0_unexpected", 64'h1, 64'h0);
                else begin
                    t = q_done0.pop_front();
                    if (!t.wr) chk("m0_rd_data", m0_rd_data, t.rdata);
                end
            end
            if (r1 && !m1_busy) begin
                if (q_done1.size() == 0) chk("done1_unexpected", 64'h1, 64'h0);
                else begin
                    t = q_done1.pop_front();
                    if (!t.wr) chk("m1_rd_data", m1_rd_data, t.rdata);
                end
            end
            prev_en = en; prev_r0 = r0; prev_r1 = r1;
        end
    end

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic do_reset();
        @(negedge clock); reset = 0;
        @(negedge clock); reset = 1;
    endtask

    // ---------------- stimulus ----------------
    initial begin : main
        int n;
        reset = 0;
        m0_rd_en = 1; m0_wr_en = 0; m1_rd_en = 0; m1_wr_en = 1;
        m0_byte_en = 0; m1_byte_en = 0; m0_addr = 0; m1_addr = 0;
        m0_wr_data = 0; m1_wr_data = 0;
        ref_mem[64'h0] = 64'h0000_0093;
        last_gap = 0; m1_busy_cnt = 0;
        repeat (2) @(negedge clock);
        chk("rst_mem_rd_en", {63'h0, mem_rd_en}, 64'h0);
        chk("rst_mem_wr_en", {63'h0, mem_wr_en}, 64'h0);
        chk("rst_mem_addr", mem_addr, 64'h0);
        chk("rst_mem_byte_en", {56'h0, mem_byte_en}, 64'h0);
        chk("rst_wr_data", wr_data, 64'h0);
        chk("rst_m0_rd_data", m0_rd_data, 64'h0);
        chk("rst_m1_rd_data", m1_rd_data, 64'h0);
        chk("rst_m0_busy", {63'h0, m0_busy}, 64'h0);
        chk("rst_m1_busy", {63'h0, m1_busy}, 64'h0);
        m0_rd_en = 0; m1_wr_en = 0;
        @(negedge clock); reset = 1;

        // Port 0 fetch of the ROM word, 2 memory busy cycles
        mem_lat = 2;
        m1_busy_cnt = 0;
        issue(0, 1, 0, 8'h0F, 64'h0, 64'h0);
        @(negedge clock);
        chk("t1_rd_en_before_edge", {63'h0, mem_rd_en}, 64'h0);
        @(negedge clock);
        chk("t1_rd_en_after_edge", {63'h0, mem_rd_en}, 64'h1);
        wait_done(0);
        chk("t1_m0_rd_data_done", m0_rd_data, 64'h0000_0093);
        release_port(0);
        chk("t1_m1_busy_never", m1_busy_cnt, 0);

        // Port 1 write then readback
        txn(1, 0, 1, 8'h0F, 64'h1008, 64'hDEAD_BEEF);
        txn(1, 1, 0, 8'h0F, 64'h1008, 64'h0);
        chk("t2_readback", m1_rd_data, 64'hDEAD_BEEF);

        // Both enables on port 1: write only
        txn(1, 1, 1, 8'hF0, 64'h1010, 64'h1122_3344_5566_7788);
        txn(1, 1, 0, 8'hFF, 64'h1010, 64'h0);
        chk("t5_rdwr_readback", m1_rd_data, 64'h1122_3344_0000_0000);

        // Tie after reset: port 0 first, then port 1 after one idle cycle
        do_reset();
        grant_log.delete();
        fork
            txn(0, 1, 0, 8'hFF, 64'h8, 64'h0);
            txn(1, 1, 0, 8'hFF, 64'h1008, 64'h0);
        join
        chk("tie1_count", grant_log.size(), 2);
        if (grant_log.size() == 2) begin
            chk("tie1_first", {63'h0, grant_log[0]}, 64'h0);
            chk("tie1_second", {63'h0, grant_log[1]}, 64'h1);
        end
        chk("tie1_idle_gap", last_gap, 2);
        // Port 0 alone leaves port 1 owed the next tie
        txn(0, 1, 0, 8'hFF, 64'h10, 64'h0);
        grant_log.delete();
        fork
            txn(0, 1, 0, 8'hFF, 64'h0, 64'h0);
            txn(1, 1, 0, 8'hFF, 64'h1010, 64'h0);
        join
        chk("tie2_count", grant_log.size(), 2);
        if (grant_log.size() == 2) begin
            chk("tie2_first", {63'h0, grant_log[0]}, 64'h1);
            chk("tie2_second", {63'h0, grant_log[1]}, 64'h0);
        end

        // Continuous fetches on port 0 with a single port 1 request
        grant_log.delete();
        fork
            begin
                for (int i = 0; i < 3; i++) txn(0, 1, 0, 8'hFF, 64'(i * 8), 64'h0);
            end
            begin
                repeat (2) @(posedge clock);
                txn(1, 1, 0, 8'hFF, 64'h1008, 64'h0);
            end
        join
        chk("cont_count", {63'h0, grant_log.size() >= 3}, 64'h1);
        if (grant_log.size() >= 3) begin
            chk("cont_g0", {63'h0, grant_log[0]}, 64'h0);
            chk("cont_g1", {63'h0, grant_log[1]}, 64'h1);
            chk("cont_g2", {63'h0, grant_log[2]}, 64'h0);
        end

        // Reset asserted while the arbiter sits in WAIT
        mem_lat = 6;
        issue(0, 1, 0, 8'hFF, 64'h0, 64'h0);
        n = 0;
        while (mem_busy !== 1'b1 && n < 50) begin @(negedge clock); n++; end
        chk("rstw_reached_busy", {63'h0, mem_busy}, 64'h1);
        @(negedge clock);
        #2 reset = 0;
        #1;
        chk("rstw_mem_rd_en", {63'h0, mem_rd_en}, 64'h0);
        chk("rstw_mem_wr_en", {63'h0, mem_wr_en}, 64'h0);
        chk("rstw_mem_addr", mem_addr, 64'h0);
        chk("rstw_mem_byte_en", {56'h0, mem_byte_en}, 64'h0);
        chk("rstw_m0_busy", {63'h0, m0_busy}, 64'h0);
        chk("rstw_m1_busy", {63'h0, m1_busy}, 64'h0);
        m0_rd_en = 0;
        q_done0.delete();
        q_bus0.delete();
        @(negedge clock); reset = 1;
        mem_lat = 2;
        txn(0, 1, 0, 8'h0F, 64'h0, 64'h0);
        chk("rstw_fresh_read", m0_rd_data, 64'h0000_0093);

        // Randomized traffic on both ports, random memory latency
        mem_lat = 0;
        fork
            begin
                for (int i = 0; i < 25; i++) begin
                    int op;
                    op = int'($urandom_range(0, 3));
                    repeat ($urandom_range(0, 3)) @(posedge clock);
                    txn(0, op != 0, op == 0, 8'($urandom), 64'($urandom_range(0, 31) * 8),
                        {$urandom, $urandom});
                end
            end
            begin
                for (int i = 0; i < 25; i++) begin
                    int op;
                    op = int'($urandom_range(0, 2));
                    repeat ($urandom_range(0, 3)) @(posedge clock);
                    txn(1, op != 1, op != 0, 8'($urandom),
                        64'h1000 + 64'($urandom_range(0, 31) * 8), {$urandom, $urandom});
                end
            end
        join
        repeat (3) @(negedge clock);
        chk("queues_drained", q_bus0.size() + q_bus1.size() + q_done0.size() + q_done1.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
